// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
//   UART peripheral on the iob bus with TX/RX FIFOs, a run-time frame format
//   (5..8 data bits, optional even/odd parity, 1 or 2 stop bits), start-bit
//   glitch rejection and sticky write-1-to-clear error flags.
//
// Ports
//   clk       clock
//   rst       asynchronous active-low reset (released synchronously inside)
//   iob_val   access request
//   iob_rdy   access done, one cycle after the access edge
//   iob_adr   byte address, only [7:0] decoded
//   iob_wen   byte write enables, any bit set means write
//   iob_wdat  write data
//   iob_rdat  registered read data
//   tx_pin    serial output, idles high
//   rx_pin    serial input, asynchronous to clk
//
// Register map
//   0x00 CTRL    b0 tx_en, b1 rx_en, [3:2] dlen, b4 par_en, b5 par_odd, b6 stop2
//   0x04 STATUS  b0 tx_busy, b1 rx_avail, b2 tx_full, b3 overrun,
//                b4 parity_err, b5 frame_err (b3..b5 write-1-to-clear)
//   0x08 BAUD    bit period is BAUD+1 clocks
//   0x0C TXDATA  write pushes wdat[7:0]
//   0x10 RXDATA  read pops the RX FIFO head
//   0x14 LEVEL   [15:8] RX count, [7:0] TX count
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int DIV_W    = 16,
    parameter int BAUD_RST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iob_val,
    output logic        iob_rdy,
    input  logic [31:0] iob_adr,
    input  logic [3:0]  iob_wen,
    input  logic [31:0] iob_wdat,
    output logic [31:0] iob_rdat,
    output logic        tx_pin,
    input  logic        rx_pin
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [TAW:0] TX_ONE = {{TAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RX_ONE = {{RAW{1'b0}}, 1'b1};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    function automatic logic [7:0] len_mask(input logic [1:0] d);
        case (d)
            2'd0:    len_mask = 8'h1F;
            2'd1:    len_mask = 8'h3F;
            2'd2:    len_mask = 8'h7F;
            default: len_mask = 8'hFF;
        endcase
    endfunction

    // Reset is asserted asynchronously but released on a clock edge, so all
    // other flops leave reset in the same cycle.
    logic rst_meta, rst_sync;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    logic [7:0] adr;
    logic access, wr_en, rd_en;
    logic sel_ctrl, sel_status, sel_baud, sel_txdata, sel_rxdata, sel_level;
    logic unused_bits;
    assign adr         = iob_adr[7:0];
    assign access      = iob_val & ~iob_rdy;
    assign wr_en       = access & (|iob_wen);
    assign rd_en       = access & ~(|iob_wen);
    assign sel_ctrl    = (adr == 8'h00);
    assign sel_status  = (adr == 8'h04);
    assign sel_baud    = (adr == 8'h08);
    assign sel_txdata  = (adr == 8'h0C);
    assign sel_rxdata  = (adr == 8'h10);
    assign sel_level   = (adr == 8'h14);
    assign unused_bits = ^{iob_adr[31:8], iob_wdat};

    logic [6:0]       ctrl;
    logic [DIV_W-1:0] baud;
    logic             overrun, parity_err, frame_err;

    // ---------------- TX FIFO ----------------
    logic [7:0] tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp, tx_count;
    logic tx_empty, tx_full, tx_push, tx_pop;
    assign tx_count = tx_wp - tx_rp;
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
    assign tx_push  = wr_en & sel_txdata & ~tx_full & ctrl[0];

    // ---------------- RX FIFO ----------------
    logic [7:0] rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wp, rx_rp, rx_count;
    logic rx_empty, rx_full, rx_push, rx_pop;
    assign rx_count = rx_wp - rx_rp;
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
    assign rx_pop   = rd_en & sel_rxdata & ~rx_empty;

    // ---------------- TX FSM signals ----------------
    logic [2:0]       tx_state, tx_bit;
    logic [DIV_W-1:0] tx_cnt;
    logic [7:0]       tx_shift, tx_head;
    logic [1:0]       tx_dlen;
    logic             tx_par_en, tx_par_val, tx_stop2, tx_stop_second;
    logic             tx_tick, tx_frame_end, tx_busy;
    assign tx_head      = tx_mem[tx_rp[TAW-1:0]];
    assign tx_tick      = (tx_cnt == '0);
    assign tx_frame_end = (tx_state == ST_STOP) && tx_tick && (!tx_stop2 || tx_stop_second);
    // Popping straight out of the last stop period keeps frames back-to-back.
    assign tx_pop       = ~tx_empty & ctrl[0] & ((tx_state == ST_IDLE) || tx_frame_end);
    assign tx_busy      = ~tx_empty | (tx_state != ST_IDLE);

    // ---------------- RX FSM signals ----------------
    logic             rx_s1, rx_s2, rx_prev;
    logic [2:0]       rx_state, rx_bit;
    logic [DIV_W-1:0] rx_cnt;
    logic [7:0]       rx_shift;
    logic [1:0]       rx_dlen;
    logic             rx_par_en, rx_par_odd, rx_par_acc, rx_par_bad;
    logic             rx_tick, rx_stop_tick;
    assign rx_tick      = (rx_cnt == '0);
    assign rx_stop_tick = (rx_state == ST_STOP) && rx_tick && ctrl[1];
    assign rx_push      = rx_stop_tick & ~rx_full;

    // Control and divisor registers.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            ctrl <= '0;
            baud <= DIV_W'(BAUD_RST);
        end else begin
            if (wr_en && sel_ctrl) ctrl <= iob_wdat[6:0];
            if (wr_en && sel_baud) baud <= iob_wdat[DIV_W-1:0];
        end
    end

    // Sticky error flags; a set event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun    <= (rx_stop_tick & rx_full) |
                          (overrun & ~(wr_en & sel_status & iob_wdat[3]));
            parity_err <= (rx_stop_tick & rx_par_bad) |
                          (parity_err & ~(wr_en & sel_status & iob_wdat[4]));
            frame_err  <= (rx_stop_tick & ~rx_s2) |
                          (frame_err & ~(wr_en & sel_status & iob_wdat[5]));
        end
    end

    // Bus response: read data is captured on the access edge.
    logic [31:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (sel_ctrl)   rd_data = {25'h0, ctrl};
        if (sel_status) rd_data = {26'h0, frame_err, parity_err, overrun,
                                   tx_full, ~rx_empty, tx_busy};
        if (sel_baud)   rd_data = 32'(baud);
        if (sel_rxdata && !rx_empty) rd_data = {24'h0, rx_mem[rx_rp[RAW-1:0]]};
        if (sel_level)  rd_data = {16'h0, 8'(rx_count), 8'(tx_count)};
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            iob_rdy  <= 1'b0;
            iob_rdat <= '0;
        end else begin
            iob_rdy <= access;
            if (rd_en) iob_rdat <= rd_data;
        end
    end

    // FIFO storage has no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= iob_wdat[7:0];
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TX_ONE;
            if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
            if (rx_push) rx_wp <= rx_wp + RX_ONE;
            if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
        end
    end

    // Transmitter: every state is one bit period of BAUD+1 clocks, counted
    // down from a value loaded at the start of the bit. The frame format is
    // latched with the byte so CTRL writes only affect later frames.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            tx_state       <= ST_IDLE;
            tx_pin         <= 1'b1;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            tx_dlen        <= '0;
            tx_par_en      <= 1'b0;
            tx_par_val     <= 1'b0;
            tx_stop2       <= 1'b0;
            tx_stop_second <= 1'b0;
        end else if (tx_pop) begin
            tx_state       <= ST_START;
            tx_pin         <= 1'b0;
            tx_cnt         <= baud;
            tx_bit         <= '0;
            tx_shift       <= tx_head;
            tx_dlen        <= ctrl[3:2];
            tx_par_en      <= ctrl[4];
            tx_par_val     <= (^(tx_head & len_mask(ctrl[3:2]))) ^ ctrl[5];
            tx_stop2       <= ctrl[6];
            tx_stop_second <= 1'b0;
        end else begin
            if (!tx_tick) tx_cnt <= tx_cnt - CNT_ONE;
            else          tx_cnt <= baud;
            case (tx_state)
                ST_IDLE: tx_pin <= 1'b1;
                ST_START: if (tx_tick) begin
                    tx_state <= ST_DATA;
                    tx_pin   <= tx_shift[0];
                end
                ST_DATA: if (tx_tick) begin
                    if (tx_bit == 3'(tx_dlen) + 3'd4) begin
                        tx_state <= tx_par_en ? ST_PARITY : ST_STOP;
                        tx_pin   <= tx_par_en ? tx_par_val : 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        tx_pin   <= tx_shift[1];
                    end
                end
                ST_PARITY: if (tx_tick) begin
                    tx_state <= ST_STOP;
                    tx_pin   <= 1'b1;
                end
                ST_STOP: if (tx_tick) begin
                    if (tx_stop2 && !tx_stop_second) begin
                        tx_stop_second <= 1'b1;
                    end else begin
                        tx_state <= ST_IDLE;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_pin;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver: the start bit is re-checked half a bit after the edge, which
    // rejects glitches and puts every later sample near mid-bit. The byte is
    // stored (or flagged as overrun) on the first stop-bit sample.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_dlen    <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_acc <= 1'b0;
            rx_par_bad <= 1'b0;
        end else if (!ctrl[1]) begin
            rx_state <= ST_IDLE;
        end else begin
            if (!rx_tick) rx_cnt <= rx_cnt - CNT_ONE;
            else          rx_cnt <= baud;
            case (rx_state)
                ST_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state   <= ST_START;
                    rx_cnt     <= baud >> 1;
                    rx_dlen    <= ctrl[3:2];
                    rx_par_en  <= ctrl[4];
                    rx_par_odd <= ctrl[5];
                end
                ST_START: if (rx_tick) begin
                    rx_state   <= rx_s2 ? ST_IDLE : ST_DATA;
                    rx_bit     <= '0;
                    rx_shift   <= '0;
                    rx_par_acc <= 1'b0;
                    rx_par_bad <= 1'b0;
                end
                ST_DATA: if (rx_tick) begin
                    rx_shift[rx_bit] <= rx_s2;
                    rx_par_acc       <= rx_par_acc ^ rx_s2;
                    if (rx_bit == 3'(rx_dlen) + 3'd4) begin
                        rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit <= rx_bit + 3'd1;
                    end
                end
                ST_PARITY: if (rx_tick) begin
                    rx_par_bad <= rx_s2 != (rx_par_acc ^ rx_par_odd);
                    rx_state   <= ST_STOP;
                end
                ST_STOP: if (rx_tick) begin
                    rx_state <= rx_s2 ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: if (rx_s2) rx_state <= ST_IDLE;
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule
